// File: rtl/rnn_fixed_pkg.sv
// Shared fixed-point helpers for the recurrent-layer datapath: width derivation,
// QN.QM constants and the matrix-vector engine state encoding.
package rnn_fixed_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int bitwidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    function automatic int addr_bitwidth(input int ncol);
        return (clog2(ncol) < 1) ? 1 : clog2(ncol);
    endfunction

    // Room for NCOL full-precision products plus the shifted bias and one rounding carry.
    function automatic int acc_bitwidth(input int bw, input int ncol);
        return 2 * bw + clog2(ncol) + 1;
    endfunction

    function automatic longint fx_one(input int qm);
        return longint'(1) << qm;
    endfunction

    function automatic longint fx_maxv(input int bw);
        return (longint'(1) << (bw - 1)) - 1;
    endfunction

    function automatic longint fx_minv(input int bw);
        return -(longint'(1) << (bw - 1));
    endfunction

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_ROUND = 2'd3;

endpackage

// File: rtl/dot_prod_sat_mac_row.sv
// One output row: signed MAC accumulator with bias preload, round-half-up
// requantisation and saturate-or-wrap overflow handling.
module mac_row
    import rnn_fixed_pkg::*;
#(
    parameter int BITWIDTH     = 18,
    parameter int QM           = 11,
    parameter int ACC_BITWIDTH = 39,
    parameter bit SATURATE     = 1'b1,
    parameter bit BIAS_EN      = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic                accumulate,
    input  logic                round,
    input  logic [BITWIDTH-1:0] bias,
    input  logic [BITWIDTH-1:0] weight,
    input  logic [BITWIDTH-1:0] x,
    output logic [BITWIDTH-1:0] value,
    output logic                overflow
);

    localparam int PROD_W = 2 * BITWIDTH;
    localparam int PAD_W  = ACC_BITWIDTH - BITWIDTH - QM;
    localparam int EXT_W  = ACC_BITWIDTH - PROD_W;
    localparam logic signed [ACC_BITWIDTH-1:0] HALF = ACC_BITWIDTH'(fx_one(QM) >>> 1);
    localparam logic [BITWIDTH-1:0] MAXV = BITWIDTH'(fx_maxv(BITWIDTH));
    localparam logic [BITWIDTH-1:0] MINV = BITWIDTH'(fx_minv(BITWIDTH));

    logic signed [ACC_BITWIDTH-1:0] acc_reg;
    logic signed [ACC_BITWIDTH-1:0] preload;
    logic signed [ACC_BITWIDTH-1:0] rounded;
    logic signed [PROD_W-1:0]       product;
    logic [BITWIDTH-1:0]            value_reg;
    logic                           overflow_reg;
    logic                           fits;

    assign product = PROD_W'($signed(weight)) * PROD_W'($signed(x));
    assign preload = BIAS_EN ? {{PAD_W{bias[BITWIDTH-1]}}, bias, {QM{1'b0}}} : '0;
    assign rounded = (acc_reg + HALF) >>> QM;
    // The rounded value fits when every bit above the result's sign bit agrees with it.
    assign fits    = (&rounded[ACC_BITWIDTH-1:BITWIDTH-1]) | ~(|rounded[ACC_BITWIDTH-1:BITWIDTH-1]);

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_reg      <= '0;
            value_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (load) begin
                acc_reg <= preload;
            end else if (accumulate) begin
                acc_reg <= acc_reg + {{EXT_W{product[PROD_W-1]}}, product};
            end
            if (round) begin
                overflow_reg <= ~fits;
                if (fits || !SATURATE) begin
                    value_reg <= rounded[BITWIDTH-1:0];
                end else begin
                    value_reg <= rounded[ACC_BITWIDTH-1] ? MINV : MAXV;
                end
            end
        end
    end

    assign value    = value_reg;
    assign overflow = overflow_reg;

endmodule

// File: rtl/dot_prod_sat.sv
// Start-triggered matrix-vector engine: one weight column per cycle into NROW
// parallel MAC rows, then a single requantise cycle before dataReady.
module dot_prod_sat
    import rnn_fixed_pkg::*;
#(
    parameter int NROW     = 32,
    parameter int NCOL     = 4,
    parameter int QN       = 6,
    parameter int QM       = 11,
    parameter bit SATURATE = 1'b1,
    parameter bit BIAS_EN  = 1'b1,
    localparam int BITWIDTH      = bitwidth(QN, QM),
    localparam int ADDR_BITWIDTH = addr_bitwidth(NCOL),
    localparam int ACC_BITWIDTH  = acc_bitwidth(BITWIDTH, NCOL)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NROW*BITWIDTH-1:0]   biasVec,
    input  logic [NROW*BITWIDTH-1:0]   weightMemOutput,
    input  logic [BITWIDTH-1:0]        inputVec,
    output logic [ADDR_BITWIDTH-1:0]   colAddressRead,
    output logic                       busy,
    output logic                       dataReady,
    output logic [NROW*BITWIDTH-1:0]   outputVec,
    output logic [NROW-1:0]            satFlags
);

    logic [1:0]               state_reg, state_next;
    logic [ADDR_BITWIDTH-1:0] addr_reg, addr_next;
    logic                     data_ready_reg;
    logic                     last_col;
    logic                     load;
    logic                     accumulate;
    logic                     round;

    assign last_col = (addr_reg == ADDR_BITWIDTH'(NCOL - 1));

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FETCH;
                    addr_next  = '0;
                end
            end
            ST_FETCH: begin
                if (last_col) begin
                    state_next = ST_DRAIN;
                    addr_next  = '0;
                end else begin
                    addr_next = addr_reg + ADDR_BITWIDTH'(1);
                end
            end
            ST_DRAIN: state_next = ST_ROUND;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            data_ready_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            data_ready_reg <= (state_reg == ST_ROUND);
        end
    end

    // RAM data lags the address by a cycle, so the first FETCH cycle has nothing to add.
    assign load       = (state_reg == ST_IDLE) && start;
    assign accumulate = ((state_reg == ST_FETCH) && (addr_reg != '0)) || (state_reg == ST_DRAIN);
    assign round      = (state_reg == ST_ROUND);

    assign colAddressRead = (state_reg == ST_FETCH) ? addr_reg : '0;
    assign busy           = (state_reg != ST_IDLE);
    assign dataReady      = data_ready_reg;

    for (genvar gi = 0; gi < NROW; gi++) begin : g_row
        mac_row #(
            .BITWIDTH    (BITWIDTH),
            .QM          (QM),
            .ACC_BITWIDTH(ACC_BITWIDTH),
            .SATURATE    (SATURATE),
            .BIAS_EN     (BIAS_EN)
        ) u_mac_row (
            .clock     (clock),
            .reset     (reset),
            .load      (load),
            .accumulate(accumulate),
            .round     (round),
            .bias      (biasVec[gi*BITWIDTH +: BITWIDTH]),
            .weight    (weightMemOutput[gi*BITWIDTH +: BITWIDTH]),
            .x         (inputVec),
            .value     (outputVec[gi*BITWIDTH +: BITWIDTH]),
            .overflow  (satFlags[gi])
        );
    end

endmodule

// File: tb/tb_dot_prod_sat.sv
// Scoreboard bench for dot_prod_sat: saturating, wrapping/no-bias and NCOL=1 instances
// checked against a plain-arithmetic model of W*x + b with round-half-up.
module tb_dot_prod_sat;

    localparam int NROW = 32;
    localparam int NCOL = 4;
    localparam int BW   = 18;
    localparam int QM   = 11;
    localparam longint ONE  = 2048;
    localparam longint MAXV = 131071;
    localparam longint MINV = -131072;

    typedef struct packed {
        logic [NROW*BW-1:0] vec;
        logic [NROW-1:0]    flags;
        int                 cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start_one = 1'b0;
    logic [NROW*BW-1:0] bias_vec = '0;
    logic [BW-1:0] wmem [NCOL][NROW];
    logic [BW-1:0] xmem [NCOL];

    logic [NROW*BW-1:0] wd_sat, wd_wrap, wd_one, out_sat, out_wrap, out_one;
    logic [BW-1:0] xd_sat, xd_wrap, xd_one;
    logic [1:0] addr_sat, addr_wrap;
    logic [0:0] addr_one;
    logic busy_sat, busy_wrap, busy_one, dr_sat, dr_wrap, dr_one;
    logic [NROW-1:0] fl_sat, fl_wrap, fl_one;

    exp_t q_sat[$], q_wrap[$], q_one[$];
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dot_prod_sat #(.NROW(NROW), .NCOL(NCOL), .QN(6), .QM(QM), .SATURATE(1'b1), .BIAS_EN(1'b1)) u_sat (
        .clock(clk), .reset(reset), .start(start), .biasVec(bias_vec), .weightMemOutput(wd_sat),
        .inputVec(xd_sat), .colAddressRead(addr_sat), .busy(busy_sat), .dataReady(dr_sat),
        .outputVec(out_sat), .satFlags(fl_sat));

    dot_prod_sat #(.NROW(NROW), .NCOL(NCOL), .QN(6), .QM(QM), .SATURATE(1'b0), .BIAS_EN(1'b0)) u_wrap (
        .clock(clk), .reset(reset), .start(start), .biasVec(bias_vec), .weightMemOutput(wd_wrap),
        .inputVec(xd_wrap), .colAddressRead(addr_wrap), .busy(busy_wrap), .dataReady(dr_wrap),
        .outputVec(out_wrap), .satFlags(fl_wrap));

    dot_prod_sat #(.NROW(NROW), .NCOL(1), .QN(6), .QM(QM), .SATURATE(1'b1), .BIAS_EN(1'b1)) u_one (
        .clock(clk), .reset(reset), .start(start_one), .biasVec(bias_vec), .weightMemOutput(wd_one),
        .inputVec(xd_one), .colAddressRead(addr_one), .busy(busy_one), .dataReady(dr_one),
        .outputVec(out_one), .satFlags(fl_one));

    // Weight RAM and input vector source with one cycle of read latency per instance.
    always @(posedge clk) begin
        for (int j = 0; j < NROW; j++) begin
            wd_sat[j*BW +: BW]  <= wmem[addr_sat][j];
            wd_wrap[j*BW +: BW] <= wmem[addr_wrap][j];
            wd_one[j*BW +: BW]  <= wmem[addr_one][j];
        end
        xd_sat  <= xmem[addr_sat];
        xd_wrap <= xmem[addr_wrap];
        xd_one  <= xmem[addr_one];
    end

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer dot product, floor((acc + half) / ONE), then range handling.
    function automatic exp_t model(input bit sat, input bit bias_en, input int ncol, input int lat);
        exp_t e;
        longint acc, t, r;
        e.vec   = '0;
        e.flags = '0;
        e.cyc   = lat;
        for (int j = 0; j < NROW; j++) begin
            acc = bias_en ? longint'($signed(bias_vec[j*BW +: BW])) * ONE : 0;
            for (int k = 0; k < ncol; k++) begin
                acc += longint'($signed(wmem[k][j])) * longint'($signed(xmem[k]));
            end
            t = acc + ONE / 2;
            r = (t >= 0) ? t / ONE : -((-t + ONE - 1) / ONE);
            if (r > MAXV || r < MINV) begin
                e.flags[j] = 1'b1;
                if (sat) r = (r > MAXV) ? MAXV : MINV;
            end
            e.vec[j*BW +: BW] = r[BW-1:0];
        end
        return e;
    endfunction

    task automatic compare(input string tag, input exp_t e, input logic [NROW*BW-1:0] vec,
                           input logic [NROW-1:0] fl);
        check({tag, "_vec"}, vec, e.vec);
        check({tag, "_flags"}, fl, e.flags);
        check({tag, "_latency"}, cyc, e.cyc);
    endtask

    always @(negedge clk) begin
        if (dr_sat) begin
            if (q_sat.size() == 0) check("sat_unexpected_ready", dr_sat, 0);
            else compare("sat", q_sat.pop_front(), out_sat, fl_sat);
        end
        if (dr_wrap) begin
            if (q_wrap.size() == 0) check("wrap_unexpected_ready", dr_wrap, 0);
            else compare("wrap", q_wrap.pop_front(), out_wrap, fl_wrap);
        end
        if (dr_one) begin
            if (q_one.size() == 0) check("one_unexpected_ready", dr_one, 0);
            else compare("one", q_one.pop_front(), out_one, fl_one);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy_sat || busy_wrap) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy_sat || busy_wrap) check("idle_timeout", busy_sat, 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q_sat.size() + q_wrap.size() + q_one.size()) != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if ((q_sat.size() + q_wrap.size() + q_one.size()) != 0) begin
            check("drain_timeout", q_sat.size() + q_wrap.size() + q_one.size(), 0);
            q_sat.delete();
            q_wrap.delete();
            q_one.delete();
        end
    endtask

    task automatic issue_main();
        q_sat.push_back(model(1'b1, 1'b1, NCOL, cyc + NCOL + 3));
        q_wrap.push_back(model(1'b0, 1'b0, NCOL, cyc + NCOL + 3));
        start = 1'b1;
    endtask

    task automatic run_main();
        wait_idle();
        issue_main();
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy_sat, 1);
        wait_drain();
    endtask

    task automatic run_one();
        int n = 0;
        while (busy_one && n < 50) begin
            @(negedge clk);
            n++;
        end
        q_one.push_back(model(1'b1, 1'b1, 1, cyc + 4));
        start_one = 1'b1;
        @(negedge clk);
        start_one = 1'b0;
        wait_drain();
    endtask

    task automatic fill(input logic [BW-1:0] w, input logic [BW-1:0] x, input logic [BW-1:0] b);
        for (int k = 0; k < NCOL; k++) begin
            xmem[k] = x;
            for (int j = 0; j < NROW; j++) wmem[k][j] = w;
        end
        for (int j = 0; j < NROW; j++) bias_vec[j*BW +: BW] = b;
    endtask

    function automatic logic [BW-1:0] rnd(input bit big);
        logic [BW-1:0] v;
        v = big ? BW'($urandom) : BW'($urandom_range(0, 8191)) - BW'(4096);
        return v;
    endfunction

    task automatic fill_random(input bit big);
        for (int k = 0; k < NCOL; k++) begin
            xmem[k] = rnd(big);
            for (int j = 0; j < NROW; j++) wmem[k][j] = rnd(big);
        end
        for (int j = 0; j < NROW; j++) bias_vec[j*BW +: BW] = rnd(big);
    endtask

    initial begin
        fill('0, '0, '0);
        repeat (3) @(negedge clk);
        check("reset_outputVec", out_sat, 0);
        check("reset_satFlags", fl_sat, 0);
        check("reset_dataReady", dr_sat, 0);
        check("reset_busy", busy_sat, 0);
        check("reset_colAddressRead", addr_sat, 0);
        check("reset_one_outputVec", out_one, 0);
        reset = 1'b0;
        @(negedge clk);

        fill(18'h00800, 18'h00800, '0);
        run_main();
        check("unity_rows", out_sat, {NROW{18'h02000}});
        check("unity_flags", fl_sat, 0);

        fill(18'h10000, 18'h10000, '0);
        run_main();
        check("sat_clip_rows", out_sat, {NROW{18'h1FFFF}});
        check("sat_clip_flags", fl_sat, {NROW{1'b1}});
        check("wrap_rows", out_wrap, {NROW{18'h00000}});
        check("wrap_flags", fl_wrap, {NROW{1'b1}});

        fill('0, '0, '0);
        xmem[0] = 18'h00001;
        for (int j = 0; j < NROW; j++) wmem[0][j] = 18'h00400;
        run_main();
        check("round_half_up", out_sat[BW-1:0], 18'h00001);
        for (int j = 0; j < NROW; j++) wmem[0][j] = 18'h3FC00;
        run_main();
        check("round_neg_half", out_sat[BW-1:0], 18'h00000);

        fill('0, 18'h00800, '0);
        for (int j = 0; j < NROW; j++) bias_vec[j*BW +: BW] = BW'(j * 2048);
        run_main();
        check("bias_row31", out_sat[31*BW +: BW], 18'(31 * 2048));
        check("bias_disabled", out_wrap, 0);

        // Abort a product with a one-cycle reset three cycles after start.
        wait_idle();
        fill_random(1'b0);
        issue_main();
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        q_sat.delete();
        q_wrap.delete();
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy_sat, 0);
        check("abort_outputVec", out_sat, 0);
        check("abort_satFlags", fl_sat, 0);
        repeat (12) @(negedge clk);
        run_main();

        // Three products with start held high the whole time.
        fill_random(1'b0);
        for (int p = 0; p < 3; p++) begin
            wait_idle();
            for (int k = 0; k < NCOL; k++) xmem[k] = rnd(1'b0);
            issue_main();
            @(negedge clk);
        end
        start = 1'b0;
        wait_drain();

        // A start pulse in the middle of a product must not queue another one.
        wait_idle();
        fill_random(1'b0);
        issue_main();
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (10) @(negedge clk);

        for (int n = 0; n < 20; n++) begin
            fill_random(n[0]);
            run_main();
        end

        fill('0, 18'h00001, '0);
        for (int j = 0; j < NROW; j++) wmem[0][j] = j[0] ? 18'h3FC00 : 18'h00400;
        run_one();
        check("one_round_row0", out_one[BW-1:0], 18'h00001);
        for (int n = 0; n < 6; n++) begin
            fill_random(n[0]);
            run_one();
        end

        wait_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
